// File: rtl/ifetch_pkg.sv
// ifetch_pkg
//   Shared definitions for the instruction-fetch controller:
//   FSM state encoding, sequential PC step, a NOP word for debug
//   visibility, and the queue entry layout (instruction + its PC).
package ifetch_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [31:0] IFETCH_PC_STEP = 32'd4;
    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    function automatic logic [31:0] next_seq_pc(input logic [31:0] pc,
                                                input logic [31:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/ifetch_queue.sv
// ifetch_queue
//   Small circular FIFO holding fetched {instruction, pc} entries.
//   The head entry is read straight out of the storage registers so the
//   consumer sees it in the same cycle it becomes valid.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flush         synchronous clear; wins over push and pop
//   push/push_data  write one entry at the tail
//   pop           retire the head entry (ignored when empty)
//   head_data     current head entry
//   count         number of stored entries
//   full, empty   occupancy flags
module ifetch_queue #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q,  count_d;
    logic             do_push;
    logic             do_pop;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign head_data = mem_q[rd_ptr_q];

    // A push into a full queue is only accepted when the head leaves
    // in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Pointers are PW bits wide, so with a power-of-two depth they wrap
    // modulo DEPTH on their own.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl
//   Fetch-side companion to the PC register. Issues single-outstanding
//   instruction-memory reads at pc_cur, steers pc_next (step, hold or
//   branch target), buffers returned words tagged with their PC and
//   presents the oldest one to IF/ID over valid/ready.
// Ports:
//   clk, reset              clock, asynchronous active-low reset
//   pc_cur / pc_next        PC register value in / next value out
//   stall                   blocks new requests only
//   branch_taken/target     one-cycle redirect; flushes wrong-path work
//   imem_req/addr           read strobe and address
//   imem_rvalid/rdata       read response
//   ifid_valid/instr/pc     queue head toward decode
//   id_ready                decode accepts the head this cycle
//
// state    | meaning
// ---------+-------------------------------------------------
// ST_IDLE  | no read outstanding; may issue
// ST_WAIT  | one read outstanding; its data will be queued
// ST_DRAIN | one stale read outstanding; its data is dropped
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter int          QDEPTH  = 2,
    parameter logic [31:0] PC_STEP = IFETCH_PC_STEP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    output logic [31:0] pc_next,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    input  logic        id_ready
);

    localparam int CW = $clog2(QDEPTH) + 1;

    logic [1:0]   state_q,  state_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         issue;
    logic         q_push;
    logic         q_pop;
    logic         q_full;
    logic         q_empty;
    logic [CW-1:0] q_count;
    fetch_entry_t q_push_entry;
    fetch_entry_t q_head;

    // Issue only from IDLE, so the queue count is exact here and a free
    // slot now is a slot reserved for the response.
    assign issue = (state_q == ST_IDLE) && !stall && !branch_taken &&
                   (q_count < CW'(QDEPTH));

    always_comb begin
        state_d  = state_q;
        req_pc_d = req_pc_q;
        q_push   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (issue) begin
                    state_d  = ST_WAIT;
                    req_pc_d = pc_cur;
                end
            end
            ST_WAIT: begin
                if (branch_taken) begin
                    state_d = imem_rvalid ? ST_IDLE : ST_DRAIN;
                end else if (imem_rvalid) begin
                    q_push  = !q_full;
                    state_d = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                // A response arriving together with a further branch still
                // retires the outstanding read.
                if (imem_rvalid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // pc_next depends only on state, queue count and the hazard/branch
    // inputs, never on imem_rvalid, so it settles early in the cycle.
    always_comb begin
        if (!reset) begin
            pc_next = '0;
        end else if (branch_taken) begin
            pc_next = branch_target;
        end else if (issue) begin
            pc_next = next_seq_pc(pc_cur, PC_STEP);
        end else begin
            pc_next = pc_cur;
        end
    end

    assign imem_req  = reset && issue;
    assign imem_addr = pc_cur;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            req_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            req_pc_q <= req_pc_d;
        end
    end

    assign q_push_entry = '{instr: imem_rdata, pc: req_pc_q};
    assign q_pop        = !q_empty && id_ready;

    ifetch_queue #(
        .DEPTH (QDEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_queue (
        .clk       (clk),
        .rst_n     (reset),
        .flush     (branch_taken),
        .push      (q_push),
        .push_data (q_push_entry),
        .pop       (q_pop),
        .head_data (q_head),
        .count     (q_count),
        .full      (q_full),
        .empty     (q_empty)
    );

    assign ifid_valid = !q_empty;
    assign ifid_instr = q_head.instr;
    assign ifid_pc    = q_head.pc;

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
Fetch-side companion to the PC register. It consumes the current PC, issues single-outstanding instruction-memory reads, and drives the next-PC value back into the PC register (pc+4, hold, or branch target). Returned instructions are buffered in a small queue, each tagged with its PC, and handed to the IF/ID stage over a valid/ready handshake. Branch redirects flush everything fetched down the wrong path.

Parameters:
QDEPTH, 2, instruction queue entries; power of 2, minimum 2.
PC_STEP, 4, byte increment per sequential fetch.

Ports:
clk  in  1  clock; all state updates on posedge.
reset  in  1  asynchronous, active-low (0 = reset asserted).
pc_cur  in  32  current PC from the PC register.
pc_next  out  32  next value to load into the PC register.
stall  in  1  hazard stall; blocks new requests only.
branch_taken  in  1  redirect request (one-cycle pulse).
branch_target  in  32  redirect address; valid while branch_taken=1.
imem_req  out  1  read strobe, one cycle per request.
imem_addr  out  32  read address; equals pc_cur when imem_req=1.
imem_rvalid  in  1  read data valid; arrives at least 1 cycle after imem_req.
imem_rdata  in  32  instruction word.
ifid_valid  out  1  queue head is valid.
ifid_instr  out  32  queue head instruction.
ifid_pc  out  32  PC of queue head instruction.
id_ready  in  1  decode accepts the head this cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; queue empty; ifid_valid=0; ifid_instr=0; ifid_pc=0; req_pc=0.
  - imem_req and pc_next are forced to 0 for as long as reset is low.
- State machine:
  - IDLE: no read outstanding.
  - WAIT: one read outstanding.
  - DRAIN: one stale read outstanding; its data is discarded.
- Issue condition, evaluated in IDLE: !stall && !branch_taken && (count + 0) < QDEPTH.
  - On issue: imem_req=1, imem_addr=pc_cur, req_pc<=pc_cur, pc_next=pc_cur+PC_STEP (mod 2^32), state goes to WAIT.
- No issue and no branch: pc_next=pc_cur (hold).
- WAIT:
  - On imem_rvalid, enqueue {imem_rdata, req_pc} and go to IDLE.
  - A space slot is guaranteed, because issue reserved it.
- Branch (branch_taken=1, any state):
  - pc_next=branch_target.
  - Queue cleared on the next edge; ifid_valid=0 the following cycle.
  - No request is issued that cycle.
  - WAIT without imem_rvalid -> DRAIN.
  - WAIT with imem_rvalid in the same cycle -> response discarded, go to IDLE.
  - IDLE stays IDLE. DRAIN stays DRAIN.
- DRAIN: on imem_rvalid, discard the data and go to IDLE. No issue while in DRAIN.
- Queue:
  - Circular buffer with rd/wr pointers that wrap modulo QDEPTH, plus a count.
  - Dequeue when ifid_valid && id_ready.
  - Enqueue and dequeue in the same cycle: count unchanged; both pointers advance.
  - Branch flush overrides any enqueue or dequeue in the same cycle.
- Stall:
  - Does not block response enqueue or dequeue.
  - Does not block a branch, which has priority over stall.
- Outputs:
  - imem_req, imem_addr, pc_next: combinational from state and inputs.
  - ifid_*: driven from queue-head registers (zero-latency view of the head entry).
- Throughput: one instruction per 2 cycles with 1-cycle memory latency, because there is a single outstanding read.
- Timing note: the PC register latches pc_next on negedge. pc_next must be stable by then, so it must have no combinational path from imem_rvalid.

Decomposition:
- Shared package ifetch_pkg:
  - State encoding: IDLE=2'd0, WAIT=2'd1, DRAIN=2'd2.
  - PC_STEP constant.
  - NOP instruction constant 32'h00000013, for debug/reset visibility.
- One natural sub-module: ifetch_queue.
  - Parameterised 64-bit-wide FIFO (instruction + PC) with synchronous flush, push/pop, count, full/empty.

Test Plan:
- Reset release, memory latency 1, id_ready=1, pc_cur sequence 0x0/0x4/0x8 -> imem_addr 0x0, 0x4, 0x8 on alternating cycles; ifid_pc 0x0, 0x4, 0x8 in order; pc_next=pc_cur+4 on issue cycles.
- id_ready=0 for 10 cycles -> exactly QDEPTH=2 entries fetched (0x0, 0x4), then imem_req stays 0 and pc_next holds 0x8; on id_ready=1, fetching resumes at 0x8.
- Branch to 0x100 while in WAIT, data arriving 2 cycles later -> data discarded (DRAIN); queue empty; next imem_addr=0x100; first ifid_pc=0x100.
- Branch and imem_rvalid in the same cycle -> response dropped, state IDLE; next cycle imem_req=1 at 0x100.
- stall=1 with a queued entry -> no new imem_req; head still dequeues; pc_next holds; clearing stall resumes issue.
- reset driven low mid-WAIT -> immediately imem_req=0, ifid_valid=0, pc_next=0; a late imem_rvalid after release is ignored (state IDLE).
